// File: rtl/crc_seg_dec.sv
// crc_seg_dec: CRC syndrome checker folding SEG_W codeword bits per cycle (rev 1.0).
// Define CRC_ERRCNT_EN to add the saturating o_errcnt error counter.
`timescale 1ns/1ps
`default_nettype none

module crc_seg_dec #(
   parameter int               DATA_W = 128,
   parameter int               CRC_W  = 9,
   parameter logic [CRC_W-1:0] POLY   = 9'h119,
   parameter int               SEG_W  = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    i_valid,
   input  logic [DATA_W+CRC_W-1:0] i_code,
   output logic                    o_ready,
   output logic [DATA_W-1:0]       o_data,
   output logic                    o_valid,
   output logic                    o_haserr
`ifdef CRC_ERRCNT_EN
   ,
   output logic [15:0]             o_errcnt
`endif
);

   localparam int NBITS  = DATA_W + CRC_W;
   localparam int NSEG   = (NBITS + SEG_W - 1) / SEG_W;
   localparam int LAST_W = NBITS - (NSEG - 1) * SEG_W;
   localparam int PAD_W  = NSEG * SEG_W;
   localparam int CNT_W  = (NSEG > 1) ? $clog2(NSEG) : 1;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  seg_cnt_q;
   logic [CRC_W-1:0]  syn_q;
   logic [CRC_W-1:0]  syn_d;
   logic [PAD_W-1:0]  code_q;
   logic [DATA_W-1:0] data_q;
   logic              valid_q;
   logic              haserr_q;
   logic [SEG_W-1:0]  seg;
   logic              last_seg;
   logic              accept;
   logic              fb;

   assign last_seg = (seg_cnt_q == CNT_W'(NSEG - 1));
   assign seg      = code_q[int'(seg_cnt_q) * SEG_W +: SEG_W];

   // The final-segment cycle may take the next codeword so throughput is one per NSEG cycles.
   assign accept  = i_valid && ((state_q == S_IDLE) || last_seg);
   assign o_ready = reset_n && enable && ((state_q == S_IDLE) || last_seg);

   // Lower index is transmitted first, i.e. it is the higher-order coefficient.
   always_comb begin
      syn_d = syn_q;
      fb    = 1'b0;
      for (int i = 0; i < SEG_W; i++) begin
         if (!last_seg || (i < LAST_W)) begin
            fb    = syn_d[CRC_W-1] ^ seg[i];
            syn_d = (syn_d << 1) ^ (fb ? POLY : '0);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         seg_cnt_q <= '0;
         syn_q     <= '0;
         code_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         haserr_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (enable) begin
            if (state_q == S_RUN) begin
               syn_q     <= syn_d;
               seg_cnt_q <= seg_cnt_q + CNT_W'(1);
               if (last_seg) begin
                  data_q    <= code_q[DATA_W-1:0];
                  haserr_q  <= (syn_d != '0);
                  valid_q   <= 1'b1;
                  state_q   <= S_IDLE;
                  seg_cnt_q <= '0;
               end
            end
            if (accept) begin
               code_q    <= PAD_W'(i_code);
               syn_q     <= '0;
               seg_cnt_q <= '0;
               state_q   <= S_RUN;
            end
         end
      end
   end

   assign o_data   = data_q;
   assign o_valid  = valid_q;
   assign o_haserr = haserr_q;

`ifdef CRC_ERRCNT_EN
   logic [15:0] errcnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         errcnt_q <= '0;
      end else if (enable && (state_q == S_RUN) && last_seg && (syn_d != '0)
                   && (errcnt_q != 16'hFFFF)) begin
         errcnt_q <= errcnt_q + 16'd1;
      end
   end

   assign o_errcnt = errcnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc_seg_dec.sv
// tb_crc_seg_dec: checks crc_seg_dec (SEG_W=32 and SEG_W=137) against a long-division model.
`timescale 1ns/1ps
`default_nettype none

module tb_crc_seg_dec;

   localparam int               DATA_W = 128;
   localparam int               CRC_W  = 9;
   localparam logic [CRC_W-1:0] POLY   = 9'h119;
   localparam int               NBITS  = DATA_W + CRC_W;
   localparam int               NSEG0  = (NBITS + 32 - 1) / 32;

   logic              clk;
   logic              reset_n;
   logic              enable;
   logic              i_valid0, i_valid1;
   logic [NBITS-1:0]  i_code0, i_code1;
   logic              o_ready0, o_ready1;
   logic [DATA_W-1:0] o_data0, o_data1;
   logic              o_valid0, o_valid1;
   logic              o_haserr0, o_haserr1;
`ifdef CRC_ERRCNT_EN
   logic [15:0]       o_errcnt0, o_errcnt1;
`endif

   int total = 0;
   int bad   = 0;
   int exp_cnt0 = 0;
   int exp_cnt1 = 0;

   crc_seg_dec #(.DATA_W(DATA_W), .CRC_W(CRC_W), .POLY(POLY), .SEG_W(32)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .i_valid(i_valid0), .i_code(i_code0), .o_ready(o_ready0),
      .o_data(o_data0), .o_valid(o_valid0), .o_haserr(o_haserr0)
`ifdef CRC_ERRCNT_EN
      , .o_errcnt(o_errcnt0)
`endif
   );

   crc_seg_dec #(.DATA_W(DATA_W), .CRC_W(CRC_W), .POLY(POLY), .SEG_W(NBITS)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .i_valid(i_valid1), .i_code(i_code1), .o_ready(o_ready1),
      .o_data(o_data1), .o_valid(o_valid1), .o_haserr(o_haserr1)
`ifdef CRC_ERRCNT_EN
      , .o_errcnt(o_errcnt1)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // Remainder of true polynomial long division; code bit 0 is the highest-degree term.
   function automatic logic [CRC_W-1:0] ref_rem(input logic [NBITS-1:0] c);
      logic [NBITS-1:0] p;
      logic [CRC_W:0]   g;
      g = {1'b1, POLY};
      for (int i = 0; i < NBITS; i++) p[NBITS-1-i] = c[i];
      for (int k = NBITS - 1; k >= CRC_W; k--)
         if (p[k]) p[k -: CRC_W+1] = p[k -: CRC_W+1] ^ g;
      return p[CRC_W-1:0];
   endfunction

   function automatic logic [NBITS-1:0] make_valid(input logic [DATA_W-1:0] d);
      logic [NBITS-1:0] c;
      logic [CRC_W-1:0] r;
      c = {{CRC_W{1'b0}}, d};
      r = ref_rem(c);
      for (int j = 0; j < CRC_W; j++) c[DATA_W+j] = r[CRC_W-1-j];
      return c;
   endfunction

   function automatic logic [NBITS-1:0] rand_code();
      logic [159:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return r[NBITS-1:0];
   endfunction

   // Presents a codeword on dut0 and returns #1 after the edge that accepted it.
   task automatic send0(input logic [NBITS-1:0] c);
      int n;
      n = 0;
      i_code0  = c;
      i_valid0 = 1'b1;
      while (!o_ready0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (o_ready0 !== 1'b1) begin
         bad++;
         $display("FAIL send_ready_timeout o_ready=%0b required=1", o_ready0);
      end
      @(posedge clk); #1;
      i_valid0 = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; enable = 1'b1;
      i_valid0 = 1'b0; i_valid1 = 1'b0; i_code0 = '0; i_code1 = '0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({o_ready0, o_ready1, o_valid0, o_haserr0} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_flags got=%b required=0000", {o_ready0, o_ready1, o_valid0, o_haserr0});
      end
      total++;
      if (o_data0 !== '0) begin
         bad++;
         $display("FAIL reset_data got=%h required=0", o_data0);
      end
`ifdef CRC_ERRCNT_EN
      total++;
      if (o_errcnt0 !== 16'd0) begin
         bad++;
         $display("FAIL reset_errcnt got=%0d required=0", o_errcnt0);
      end
`endif
      reset_n = 1'b1;
      #1;
      total++;
      if ({o_ready0, o_ready1} !== 2'b11) begin
         bad++;
         $display("FAIL reset_release_ready got=%b required=11", {o_ready0, o_ready1});
      end
   endtask

   task automatic test_single(input logic [NBITS-1:0] c, input string name);
      logic e;
      e = (ref_rem(c) != '0);
      send0(c);
      for (int k = 1; k <= NSEG0; k++) begin
         @(posedge clk); #1;
         total++;
         if (o_valid0 !== (k == NSEG0)) begin
            bad++;
            $display("FAIL %s_latency cycle=%0d o_valid=%0b required=%0b", name, k, o_valid0, k == NSEG0);
         end
      end
      if (e) exp_cnt0++;
      total++;
      if ({o_haserr0, o_data0} !== {e, c[DATA_W-1:0]}) begin
         bad++;
         $display("FAIL %s_result haserr=%0b data=%h required haserr=%0b data=%h",
                  name, o_haserr0, o_data0, e, c[DATA_W-1:0]);
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({o_valid0, o_haserr0, o_data0} !== {1'b0, e, c[DATA_W-1:0]}) begin
         bad++;
         $display("FAIL %s_hold valid=%0b haserr=%0b data=%h required valid=0 haserr=%0b data=%h",
                  name, o_valid0, o_haserr0, o_data0, e, c[DATA_W-1:0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [NBITS-1:0] c1, c2;
      logic e1, e2;
      time t1, t2;
      c1 = 137'h50000; c2 = 137'hb0000;
      e1 = (ref_rem(c1) != '0); e2 = (ref_rem(c2) != '0);
      send0(c1);
      send0(c2);
      t1 = $time;
      if (e1) exp_cnt0++;
      total++;
      if ({o_valid0, o_haserr0, o_data0} !== {1'b1, e1, c1[DATA_W-1:0]}) begin
         bad++;
         $display("FAIL b2b_first valid=%0b haserr=%0b data=%h required valid=1 haserr=%0b data=%h",
                  o_valid0, o_haserr0, o_data0, e1, c1[DATA_W-1:0]);
      end
      t2 = 0;
      for (int k = 1; k <= NSEG0 + 2 && t2 == 0; k++) begin
         @(posedge clk); #1;
         if (o_valid0 === 1'b1) t2 = $time;
      end
      if (e2) exp_cnt0++;
      total++;
      if ((t2 - t1) !== 50) begin
         bad++;
         $display("FAIL b2b_spacing got=%0t required=50", t2 - t1);
      end
      total++;
      if ({o_haserr0, o_data0} !== {e2, c2[DATA_W-1:0]}) begin
         bad++;
         $display("FAIL b2b_second haserr=%0b data=%h required haserr=%0b data=%h",
                  o_haserr0, o_data0, e2, c2[DATA_W-1:0]);
      end
`ifdef CRC_ERRCNT_EN
      total++;
      if (o_errcnt0 !== 16'(exp_cnt0)) begin
         bad++;
         $display("FAIL b2b_errcnt got=%0d required=%0d", o_errcnt0, exp_cnt0);
      end
`endif
   endtask

   task automatic test_stall();
      logic [NBITS-1:0] c;
      logic e;
      c = make_valid(128'h1);
      e = (ref_rem(c) != '0);
      send0(c);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (k == 2) enable = 1'b0;
         if (k == 5) enable = 1'b1;
         total++;
         if (o_valid0 !== (k == 8)) begin
            bad++;
            $display("FAIL stall_latency cycle=%0d o_valid=%0b required=%0b", k, o_valid0, k == 8);
         end
      end
      total++;
      if ({o_haserr0, o_data0} !== {e, c[DATA_W-1:0]} || e !== 1'b0) begin
         bad++;
         $display("FAIL stall_result haserr=%0b data=%h required haserr=0 data=%h",
                  o_haserr0, o_data0, c[DATA_W-1:0]);
      end
   endtask

   task automatic test_midreset();
      int seen;
      send0(137'h1_2345_6789);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b0;
      exp_cnt0 = 0; exp_cnt1 = 0;
      #1;
      total++;
      if ({o_ready0, o_valid0, o_haserr0} !== 3'b000 || o_data0 !== '0) begin
         bad++;
         $display("FAIL midreset_outputs ready=%0b valid=%0b haserr=%0b data=%h required all 0",
                  o_ready0, o_valid0, o_haserr0, o_data0);
      end
`ifdef CRC_ERRCNT_EN
      total++;
      if (o_errcnt0 !== 16'd0) begin
         bad++;
         $display("FAIL midreset_errcnt got=%0d required=0", o_errcnt0);
      end
`endif
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      total++;
      if (o_ready0 !== 1'b1) begin
         bad++;
         $display("FAIL midreset_ready got=%0b required=1", o_ready0);
      end
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (o_valid0 !== 1'b0) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL midreset_no_valid pulses=%0d required=0", seen);
      end
   endtask

   task automatic test_random_full_width();
      logic [NBITS-1:0] c, prev;
      logic e_prev;
      prev = '0; e_prev = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         c = rand_code();
         if ($urandom_range(1, 0) == 1) c = make_valid(c[DATA_W-1:0]);
         i_code1  = c;
         i_valid1 = 1'b1;
         total++;
         if (o_ready1 !== 1'b1) begin
            bad++;
            $display("FAIL rand_ready n=%0d got=%0b required=1", n, o_ready1);
         end
         @(posedge clk); #1;
         total++;
         if (n == 0) begin
            if (o_valid1 !== 1'b0) begin
               bad++;
               $display("FAIL rand_first_valid got=%0b required=0", o_valid1);
            end
         end else if ({o_valid1, o_haserr1, o_data1} !== {1'b1, e_prev, prev[DATA_W-1:0]}) begin
            bad++;
            $display("FAIL rand_result n=%0d valid=%0b haserr=%0b data=%h required valid=1 haserr=%0b data=%h",
                     n - 1, o_valid1, o_haserr1, o_data1, e_prev, prev[DATA_W-1:0]);
         end
         prev   = c;
         e_prev = (ref_rem(c) != '0);
         if (e_prev) exp_cnt1++;
      end
      i_valid1 = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({o_valid1, o_haserr1, o_data1} !== {1'b1, e_prev, prev[DATA_W-1:0]}) begin
         bad++;
         $display("FAIL rand_last valid=%0b haserr=%0b data=%h required valid=1 haserr=%0b data=%h",
                  o_valid1, o_haserr1, o_data1, e_prev, prev[DATA_W-1:0]);
      end
      @(posedge clk); #1;
      total++;
      if (o_valid1 !== 1'b0) begin
         bad++;
         $display("FAIL rand_pulse_end got=%0b required=0", o_valid1);
      end
`ifdef CRC_ERRCNT_EN
      total++;
      if (o_errcnt1 !== 16'(exp_cnt1)) begin
         bad++;
         $display("FAIL rand_errcnt got=%0d required=%0d", o_errcnt1, exp_cnt1);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single('0, "zero");
      test_single(137'h1000, "single_bit");
      test_back_to_back();
      test_stall();
      test_midreset();
      test_random_full_width();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
